// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, block/word types, core FSM states,
// and the byte-level helpers used by the cipher round (xtime, MixColumns on
// one column, ShiftRows on a full block). Byte 0 is bits [127:120] and the
// state is laid out column-major.
package aes_pkg;

  localparam int unsigned AES_NR  = 10;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned IDX_W   = 2;

  // Word 0 (most significant, bits [127:96]) lives at element 3, so word i
  // of a block is element ~i for a 2-bit index.
  typedef logic [3:0][WORD_W-1:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_KEY,
    FETCH,
    ROUND,
    OUT
  } aes_core_state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one 32-bit column; a0 is the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Row r of the state rotates left by r columns: out[r][c] = in[r][(c+r)%4].
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational, full 256-entry table.
// Ports: x - input byte; y - substituted byte.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0 is the most significant byte, so lookup index is ~x.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[~x];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core fed by an external round-key expander.
// Loads four plaintext words, waits for key_ready, then runs 11 AddRoundKey
// stages, fetching each round key one word per cycle, and emits the
// ciphertext as four words with out_valid.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle pulse starting a plaintext load
//   data_in[31:0]       plaintext word, MS word first, on the 4 edges after start
//   key_ready           expander done; round keys valid while high
//   round_key[31:0]     expander word for round_key_num/r_index (same cycle)
//   round_key_num[3:0]  requested round key, 0..10
//   r_index[1:0]        requested word, 0 = bits [127:96]
//   data_out[31:0]      ciphertext word, MS word first
//   out_valid           data_out valid
//   busy                operation in progress
// Build option: AES_CORE_ABORT_EN - when defined, start outside IDLE aborts
// the current operation and begins a new load; otherwise it is ignored.
module aes_cipher_core
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              key_ready,
  input  logic [WORD_W-1:0] round_key,
  output logic [RND_W-1:0]  round_key_num,
  output logic [IDX_W-1:0]  r_index,
  output logic [WORD_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy
);

  aes_core_state_t state, state_next;

  block_t            pt_reg, pt_next;
  block_t            st_reg, st_next;
  block_t            rk_reg, rk_next;
  logic [IDX_W-1:0]  load_cnt, load_cnt_next;
  logic [IDX_W-1:0]  out_cnt, out_cnt_next;
  logic [RND_W-1:0]  round_key_num_next;
  logic [IDX_W-1:0]  r_index_next;
  logic [WORD_W-1:0] data_out_next;
  logic              out_valid_next;
  logic              busy_next;

  logic [BLOCK_W-1:0] st_bits;
  logic [BLOCK_W-1:0] rk_bits;
  logic [BLOCK_W-1:0] sub_bytes;
  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] mixed;
  logic [BLOCK_W-1:0] round_out;

  assign st_bits = st_reg;
  assign rk_bits = rk_reg;

  // SubBytes: one S-box per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x (st_bits[127 - 8*i -: 8]),
      .y (sub_bytes[127 - 8*i -: 8])
    );
  end

  assign shifted = shift_rows(sub_bytes);
  assign mixed   = {mix_column(shifted[127:96]), mix_column(shifted[95:64]),
                    mix_column(shifted[63:32]),  mix_column(shifted[31:0])};

  // Round 0 is the bare key whitening; the final round skips MixColumns.
  always_comb begin
    if (round_key_num == '0) begin
      round_out = st_bits ^ rk_bits;
    end else if (round_key_num == RND_W'(AES_NR)) begin
      round_out = shifted ^ rk_bits;
    end else begin
      round_out = mixed ^ rk_bits;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pt_reg        <= '0;
      st_reg        <= '0;
      rk_reg        <= '0;
      load_cnt      <= '0;
      out_cnt       <= '0;
      round_key_num <= '0;
      r_index       <= '0;
      data_out      <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      pt_reg        <= pt_next;
      st_reg        <= st_next;
      rk_reg        <= rk_next;
      load_cnt      <= load_cnt_next;
      out_cnt       <= out_cnt_next;
      round_key_num <= round_key_num_next;
      r_index       <= r_index_next;
      data_out      <= data_out_next;
      out_valid     <= out_valid_next;
      busy          <= busy_next;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_next         = state;
    pt_next            = pt_reg;
    st_next            = st_reg;
    rk_next            = rk_reg;
    load_cnt_next      = load_cnt;
    out_cnt_next       = out_cnt;
    round_key_num_next = round_key_num;
    r_index_next       = r_index;
    data_out_next      = data_out;
    out_valid_next     = out_valid;
    busy_next          = busy;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next         = LOAD;
          load_cnt_next      = '0;
          round_key_num_next = '0;
          r_index_next       = '0;
          busy_next          = 1'b1;
        end
      end

      LOAD: begin
        pt_next[~load_cnt] = data_in;
        load_cnt_next      = load_cnt + IDX_W'(1);
        if (load_cnt == IDX_W'(3)) begin
          state_next = WAIT_KEY;
        end
      end

      WAIT_KEY: begin
        if (key_ready) begin
          st_next            = pt_reg;
          round_key_num_next = '0;
          r_index_next       = '0;
          state_next         = FETCH;
        end
      end

      FETCH: begin
        // Expander reload: drop this pass and restart from the saved plaintext.
        if (!key_ready) begin
          round_key_num_next = '0;
          r_index_next       = '0;
          state_next         = WAIT_KEY;
        end else begin
          rk_next[~r_index] = round_key;
          r_index_next      = r_index + IDX_W'(1);
          if (r_index == IDX_W'(3)) begin
            state_next = ROUND;
          end
        end
      end

      ROUND: begin
        if (!key_ready) begin
          round_key_num_next = '0;
          r_index_next       = '0;
          state_next         = WAIT_KEY;
        end else begin
          st_next = round_out;
          if (round_key_num == RND_W'(AES_NR)) begin
            // First ciphertext word leaves on the same edge as the last round.
            data_out_next  = round_out[127:96];
            out_valid_next = 1'b1;
            out_cnt_next   = IDX_W'(1);
            state_next     = OUT;
          end else begin
            round_key_num_next = round_key_num + RND_W'(1);
            state_next         = FETCH;
          end
        end
      end

      OUT: begin
        // out_cnt wraps to 0 once word 3 has been presented.
        if (out_cnt == '0) begin
          data_out_next  = '0;
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
          state_next     = IDLE;
        end else begin
          data_out_next = st_reg[~out_cnt];
          out_cnt_next  = out_cnt + IDX_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef AES_CORE_ABORT_EN
    if (start && (state != IDLE)) begin
      state_next         = LOAD;
      load_cnt_next      = '0;
      out_cnt_next       = '0;
      round_key_num_next = '0;
      r_index_next       = '0;
      data_out_next      = '0;
      out_valid_next     = 1'b0;
      busy_next          = 1'b1;
    end
`else
    // start while busy is ignored.
`endif
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboard bench for aes_cipher_core. Stimulus pushes expected ciphertext
// words (with the cycle each must appear on) into a queue; a monitor pops and
// compares whenever out_valid is high. Round keys come from a bench-side
// key expansion driven combinationally from round_key_num/r_index.
module tb_aes_cipher_core;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic        key_ready;
  logic [31:0] round_key;
  logic [3:0]  round_key_num;
  logic [1:0]  r_index;
  logic [31:0] data_out;
  logic        out_valid;
  logic        busy;

  aes_cipher_core dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .data_in       (data_in),
    .key_ready     (key_ready),
    .round_key     (round_key),
    .round_key_num (round_key_num),
    .r_index       (r_index),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [255:0][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Expanded key schedules: index 0 = App. B key, 1 = C.1 key.
  logic [31:0] ks [2][44];
  int          key_sel = 0;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SB[~w[31:24]], SB[~w[23:16]], SB[~w[15:8]], SB[~w[7:0]]};
  endfunction

  task automatic expand(input int k, input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) ks[k][i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ks[k][i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      ks[k][i] = ks[k][i-4] ^ t;
    end
  endtask

  always_comb begin
    if (round_key_num <= 4'd10)
      round_key = ks[key_sel][int'(round_key_num) * 4 + int'(r_index)];
    else
      round_key = 32'h0;
  end

  typedef struct {
    logic [31:0] w;
    int          t;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid output word must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out_valid: got data_out %h, expected no output (cycle %0d)",
                 data_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ct_word", data_out, e.w);
        check("ct_cycle", 32'(cyc), 32'(e.t));
      end
    end
  end

  task automatic expect_ct(input logic [127:0] ct, input int t);
    for (int i = 0; i < 4; i++) q.push_back('{ct[127 - 32*i -: 32], t + i});
  endtask

  // Called at a negedge; start is sampled on the next edge (T0). Returns with
  // cyc = t0 + 4 after the last plaintext word has been sampled.
  task automatic issue(input logic [127:0] pt, output int t0);
    start = 1'b1;
    @(negedge clk);
    t0    = cyc;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = pt[127 - 32*i -: 32];
      @(negedge clk);
    end
    data_in = 32'h0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d words outstanding, expected 0", name, q.size());
      q.delete();
    end
    @(negedge clk);
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_valid_end"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_data_out"}, data_out, 32'h0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_rk_num"}, 32'(round_key_num), 32'd0);
    check({name, "_r_index"}, 32'(r_index), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;
    expand(0, KEY_B);
    expand(1, KEY_C);
    reset     = 1'b1;
    start     = 1'b0;
    data_in   = 32'h0;
    key_ready = 1'b1;
    key_sel   = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 App. B with keys already valid.
    issue(PT_B, t0);
    expect_ct(CT_B, t0 + 60);
    check("appb_busy", 32'(busy), 32'd1);
    wait_until(t0 + 7);
    check("appb_fetch_idx", 32'({round_key_num, r_index}), 32'({4'd0, 2'd2}));
    wait_until(t0 + 11);
    check("appb_fetch_r1", 32'({round_key_num, r_index}), 32'({4'd1, 2'd1}));
    drain("appb");

    // FIPS-197 C.1.
    key_sel = 1;
    issue(PT_C, t0);
    expect_ct(CT_C, t0 + 60);
    drain("c1");

    // Key stall: key_ready low for 20 cycles after the load.
    key_sel   = 0;
    key_ready = 1'b0;
    issue(PT_B, t0);
    expect_ct(CT_B, t0 + 80);
    for (int i = 0; i < 20; i++) begin
      check("stall_rk_req", 32'({round_key_num, r_index}), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    key_ready = 1'b1;
    drain("stall");

    // Key drop during round 5 FETCH: restart from round 0.
    issue(PT_B, t0);
    expect_ct(CT_B, t0 + 88);
    wait_until(t0 + 30);
    check("drop_rk_num_r5", 32'(round_key_num), 32'd5);
    wait_until(t0 + 31);
    key_ready = 1'b0;
    @(negedge clk);
    check("drop_rk_num_restart", 32'(round_key_num), 32'd0);
    key_ready = 1'b1;
    @(negedge clk);
    check("drop_wait_exit_idx", 32'({round_key_num, r_index}), 32'd0);
    drain("drop");

    // start arriving mid-round.
    key_sel = 0;
    issue(PT_B, t0);
    wait_until(t0 + 19);
    issue(PT_C, t1);
`ifdef AES_CORE_ABORT_EN
    key_sel = 1;
    expect_ct(CT_C, t1 + 60);
`else
    expect_ct(CT_B, t0 + 60);
`endif
    drain("midstart");
    key_sel = 0;

    // Reset while in a ROUND cycle, then a clean run.
    issue(PT_B, t0);
    wait_until(t0 + 24);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(PT_B, t0);
    expect_ct(CT_B, t0 + 60);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative AES-128 encryption datapath that sits directly downstream of the round-key expander. It loads a 128-bit plaintext block as four 32-bit words, waits for the expander's `done`, and runs the 11 AddRoundKey stages (initial plus 10 rounds). Round keys are fetched one 32-bit word per cycle through the expander's `round_key_num`/`r_index` read port. The 128-bit ciphertext is returned as four 32-bit words.

## Interface
- `NR`, 10: number of rounds; fixed for AES-128.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse; begins plaintext load
- `data_in`  in  32  plaintext word; most-significant word first, sampled on the 4 edges after `start`
- `key_ready`  in  1  from expander `done`; round keys valid while high
- `round_key`  in  32  combinational word returned by the expander for the current `round_key_num`/`r_index`
- `round_key_num`  out  4  round key requested, 0..10
- `r_index`  out  2  word requested; 0 = bits [127:96]
- `data_out`  out  32  ciphertext word; most-significant word first
- `out_valid`  out  1  `data_out` valid
- `busy`  out  1  high from the edge sampling `start` until the last output word retires

## Operation
- FSM states are IDLE, LOAD, WAIT_KEY, FETCH, ROUND, OUT.
- **IDLE**: on `start`, clear `load_cnt` and go to LOAD. Assert `busy`.
- **LOAD**: capture `data_in` into `pt_reg` words 0..3 on 4 consecutive edges, then go to WAIT_KEY.
- **WAIT_KEY**: on an edge with `key_ready=1`:
  - copy `pt_reg` into `st_reg`;
  - set `rnd=0` and `r_index=0`;
  - go to FETCH.
- **FETCH**:
  - Drive `round_key_num=rnd` and the current `r_index`.
  - Capture `round_key` into `rk_reg` word `r_index` on each edge.
  - After word 3, go to ROUND.
- **ROUND**: one cycle, all transforms combinational on `st_reg`/`rk_reg`.
  - `rnd=0`: `st ^= rk`.
  - `rnd=1..9`: SubBytes, then ShiftRows, then MixColumns, then `^rk`.
  - `rnd=10`: SubBytes, then ShiftRows, then `^rk` (no MixColumns).
  - If `rnd<10`: increment `rnd`, go to FETCH. Otherwise go to OUT.
- **OUT**: drive `st_reg` words 0..3 on 4 consecutive cycles with `out_valid=1`, then go to IDLE and drop `busy`.
- **Byte order**: byte 0 = `st[127:120]`; column-major per FIPS-197.
- **MixColumns**: xtime is `{b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00)`.
- **`key_ready` falling during FETCH or ROUND** (expander reloading): return to WAIT_KEY. Restart from `rnd=0` using the preserved `pt_reg`. No output is produced for the aborted pass.
- **`key_ready` falling during OUT**: ignored.
- **`start` while `busy`**: ignored (see Configuration).
- **Reset values**: `data_out=0`, `out_valid=0`, `busy=0`, `round_key_num=0`, `r_index=0`. All internal registers are cleared and the FSM is in IDLE.
- **Reset asserted mid-operation**: immediate return to reset values; partial results are discarded.

## Timing
- `start` is sampled at edge T0. Plaintext words are sampled at T1..T4.
- With `key_ready` already high, WAIT_KEY exits at T5.
- Round r:
  - FETCH edges T(6+5r)..T(9+5r);
  - ROUND edge T(10+5r).
- The round 10 ROUND edge is T60.
- `out_valid` is high after edges T60..T63, and `data_out` holds word 0..3 in turn. `out_valid` and `busy` fall after T64.
- Latency from `start` to the first ciphertext word is 60 cycles, plus any WAIT_KEY stall.
- `round_key_num` and `r_index` are registered. `round_key` is consumed in the same cycle they are presented.
- `out_valid` carries no backpressure; the consumer must accept all 4 words.

## Configuration
- Macro: `AES_CORE_ABORT_EN`.
- **Defined**: a `start` pulse in any state other than IDLE aborts the current operation:
  - `out_valid` drops on the next edge;
  - the FSM enters LOAD with `load_cnt=0`;
  - `busy` stays high.
- **Undefined**: `start` is ignored while `busy=1`.

## Structure
- **Shared package `aes_pkg`**:
  - state enum `aes_core_state_t`;
  - `AES_NR=10`;
  - functions `xtime`, `mix_column` (32-bit), `shift_rows` (128-bit).
- **Sub-module `aes_sbox`**: 8-bit combinational S-box, full 256-entry FIPS-197 table. It is instantiated 16 times for SubBytes and is reused by the expander.

## Test plan
- **FIPS-197 App. B**:
  - key `2b7e1516 28aed2a6 abf71588 09cf4f3c`, `key_ready` already high;
  - plaintext `3243f6a8 885a308d 313198a2 e0370734`;
  - expect `3925841d 02dc09fb dc118597 196a0b32` after T60..T63.
- **FIPS-197 C.1**:
  - key `00010203..0e0f`, plaintext `00112233 44556677 8899aabb ccddeeff`;
  - expect `69c4e0d8 6a7b0430 d8cdb780 70b4c55a`.
- **Key stall**: hold `key_ready=0` for 20 cycles after load. Expect `round_key_num`/`r_index` static, then the correct App. B ciphertext 20 cycles late.
- **Key drop**: pulse `key_ready` low during round 5 FETCH. Expect a restart from `round_key_num=0` and a correct ciphertext with no spurious `out_valid`.
- **`start` mid-round**:
  - without the macro: `start` is ignored and the first result completes;
  - with `AES_CORE_ABORT_EN`: the new plaintext's ciphertext is produced and the old one never appears.
- **Reset during ROUND**: all outputs are 0 on the next sample. A subsequent App. B run still matches.
